stage_sequencer: RTL



---
 rtl/stage_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Runs a fixed chain of HLS child blocks one at a time, in ascending stage
//   order. Only stages enabled in the mask captured at start are run. Both the
//   function-level side and the child side use the ap_ctrl_hs handshake.
//   Cycle counters let simulation monitors cross-check the latency of each
//   stage and of the whole run.
//
// Ports
//   ap_clk, ap_rst_n : clock, synchronous active-low reset
//   ap_start         : run request, accepted only while idle
//   ap_done/ap_ready : one-cycle pulse when a run completes
//   ap_idle          : high while no run is in progress
//   stage_en         : per-stage enable mask, captured when ap_start is accepted
//   grp_start        : per-child ap_start, at most one bit high at a time
//   grp_ready        : per-child ap_ready
//   grp_done         : per-child ap_done
//   cur_stage        : active stage index, 0 when no stage is active
//   stage_cycles     : per-stage cycle counts, stage i at [i*CNT_W +: CNT_W]
//   total_cycles     : non-idle cycles of the last or current run
module stage_sequencer #(
  parameter int N_STAGES = 3,
  parameter int CNT_W    = 32
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      ap_start,
  output logic                      ap_done,
  output logic                      ap_idle,
  output logic                      ap_ready,
  input  logic [N_STAGES-1:0]       stage_en,
  output logic [N_STAGES-1:0]       grp_start,
  input  logic [N_STAGES-1:0]       grp_ready,
  input  logic [N_STAGES-1:0]       grp_done,
  output logic [7:0]                cur_stage,
  output logic [N_STAGES*CNT_W-1:0] stage_cycles,
  output logic [CNT_W-1:0]          total_cycles
);

  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state;
  state_t              stateNext;
  logic [N_STAGES-1:0] mask;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idxNext;
  logic [IDX_W-1:0]    firstIdx;
  logic                firstValid;
  logic [IDX_W-1:0]    followIdx;
  logic                followValid;
  logic                stageDone;
  logic                stageActive;
  logic [CNT_W-1:0]    stageCnt [N_STAGES];
  logic [CNT_W-1:0]    totalCnt;

  // Lowest enabled stage of the incoming mask; the mask register is not yet
  // loaded in the cycle the start is accepted, so stage_en is searched directly.
  always_comb begin
    firstIdx   = '0;
    firstValid = 1'b0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (stage_en[i]) begin
        firstIdx   = IDX_W'(i);
        firstValid = 1'b1;
      end
    end
  end

  // Next enabled stage strictly above the current one.
  always_comb begin
    followIdx   = '0;
    followValid = 1'b0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(idx))) begin
        followIdx   = IDX_W'(i);
        followValid = 1'b1;
      end
    end
  end

  // Ready and done in the same ISSUE cycle count as completion, so a
  // one-cycle child skips WAIT entirely.
  assign stageActive = (state == ISSUE) || (state == WAIT);
  assign stageDone   = ((state == ISSUE) && grp_ready[idx] && grp_done[idx]) ||
                       ((state == WAIT) && grp_done[idx]);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    case (state)
      IDLE: begin
        if (ap_start) begin
          if (firstValid) begin
            stateNext = ISSUE;
            idxNext   = firstIdx;
          end else begin
            stateNext = DONE;
          end
        end
      end
      ISSUE, WAIT: begin
        if (stageDone) begin
          if (followValid) begin
            stateNext = ISSUE;
            idxNext   = followIdx;
          end else begin
            stateNext = DONE;
          end
        end else if ((state == ISSUE) && grp_ready[idx]) begin
          stateNext = WAIT;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // All outputs decode from registered state and index only.
  always_comb begin
    ap_idle   = (state == IDLE);
    ap_done   = (state == DONE);
    ap_ready  = (state == DONE);
    cur_stage = stageActive ? 8'(idx) : 8'd0;
    grp_start = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      grp_start[i] = (state == ISSUE) && (int'(idx) == i);
    end
  end

  // Stage index, captured mask and saturating cycle counters. Counters clear
  // on an accepted start and otherwise hold their value between runs.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      idx      <= '0;
      mask     <= '0;
      totalCnt <= '0;
      for (int i = 0; i < N_STAGES; i++) begin
        stageCnt[i] <= '0;
      end
    end else begin
      idx <= idxNext;
      if ((state == IDLE) && ap_start) begin
        mask     <= stage_en;
        totalCnt <= '0;
        for (int i = 0; i < N_STAGES; i++) begin
          stageCnt[i] <= '0;
        end
      end else begin
        if ((state != IDLE) && (totalCnt != CNT_MAX)) begin
          totalCnt <= totalCnt + CNT_ONE;
        end
        for (int i = 0; i < N_STAGES; i++) begin
          if (stageActive && (int'(idx) == i) && (stageCnt[i] != CNT_MAX)) begin
            stageCnt[i] <= stageCnt[i] + CNT_ONE;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < N_STAGES; g++) begin : g_flat
    assign stage_cycles[g*CNT_W +: CNT_W] = stageCnt[g];
  end

  assign total_cycles = totalCnt;

endmodule
